// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - skewed-carry pipelined adder with valid/ready handshake
// Optional feature macro: PIPE_ADDER_SUB_EN (adds in_sub, subtract mode)
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CHUNK = WIDTH / STAGES;

  // Subtract request; tied low in the add-only build so the datapath is shared.
  logic sub_in;
`ifdef PIPE_ADDER_SUB_EN
  assign sub_in = in_sub;
`else
  assign sub_in = 1'b0;
`endif

  // Stage registers. a/b keep the operand bits still to be added, s keeps
  // the sum bits already produced, c is the carry into the next chunk.
  logic             v_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sub_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];

  // Per-stage inputs (either the ports or the previous stage) and results.
  logic             src_v   [STAGES];
  logic             src_ci  [STAGES];
  logic             src_sub [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_s   [STAGES];
  logic [CHUNK:0]   part    [STAGES];
  logic [WIDTH-1:0] nxt_s   [STAGES];
  logic             nxt_c   [STAGES];

  // The whole pipe advances together; a full output that is not taken
  // freezes every stage. Depends only on out_ready and registered state.
  assign in_ready = out_ready | ~v_q[STAGES-1];

  // Select each stage's source and add its CHUNK-bit slice plus carry-in.
  always_comb begin
    // Stage 0 takes the ports. Subtraction is a + ~b + 1, so carry-in is
    // forced to 1 and in_c is ignored.
    src_v[0]   = in_valid;
    src_a[0]   = in_a;
    src_b[0]   = in_b;
    src_s[0]   = '0;
    src_sub[0] = sub_in;
    src_ci[0]  = sub_in | in_c;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]   = v_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_s[k]   = s_q[k-1];
      src_sub[k] = sub_q[k-1];
      src_ci[k]  = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
              + {1'b0, src_b[k][k*CHUNK +: CHUNK] ^ {CHUNK{src_sub[k]}}}
              + (CHUNK+1)'(src_ci[k]);
      nxt_s[k] = src_s[k];
      nxt_s[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      nxt_c[k] = part[k][CHUNK];
    end
  end

  // Advance all stages on a free pipe; data only loads behind a valid bit
  // so bubbles leave the previous (already X-free) contents in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
    end else if (in_ready) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= src_v[k];
        if (src_v[k]) begin
          c_q[k]   <= nxt_c[k];
          sub_q[k] <= src_sub[k];
          a_q[k]   <= src_a[k];
          b_q[k]   <= src_b[k];
          s_q[k]   <= nxt_s[k];
        end
      end
    end
  end

  assign out_s     = s_q[STAGES-1];
  assign out_c     = c_q[STAGES-1];
  assign out_valid = v_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder (three configurations)
module tb_pipe_adder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8, STAGES=4 instance: streaming, stall, random and reset tests
  logic [7:0] a4 = '0, b4 = '0, s4;
  logic c4 = 1'b0, sub4 = 1'b0, v4 = 1'b0, rdy4, co4, ov4, ordy4 = 1'b1;
  // WIDTH=8, STAGES=2 instance: latency test
  logic [7:0] a2 = '0, b2 = '0, s2;
  logic c2 = 1'b0, sub2 = 1'b0, v2 = 1'b0, rdy2, co2, ov2, ordy2 = 1'b1;
  // WIDTH=5, STAGES=1 instance: exhaustive test
  logic [4:0] a1 = '0, b1 = '0, s1;
  logic c1 = 1'b0, sub1 = 1'b0, v1 = 1'b0, rdy1, co1, ov1, ordy1 = 1'b1;

  pipe_adder #(.WIDTH(8), .STAGES(4)) u4 (
    .clk(clk), .reset(reset), .in_a(a4), .in_b(b4), .in_c(c4),
`ifdef PIPE_ADDER_SUB_EN
    .in_sub(sub4),
`endif
    .in_valid(v4), .in_ready(rdy4), .out_s(s4), .out_c(co4),
    .out_valid(ov4), .out_ready(ordy4));

  pipe_adder #(.WIDTH(8), .STAGES(2)) u2 (
    .clk(clk), .reset(reset), .in_a(a2), .in_b(b2), .in_c(c2),
`ifdef PIPE_ADDER_SUB_EN
    .in_sub(sub2),
`endif
    .in_valid(v2), .in_ready(rdy2), .out_s(s2), .out_c(co2),
    .out_valid(ov2), .out_ready(ordy2));

  pipe_adder #(.WIDTH(5), .STAGES(1)) u1 (
    .clk(clk), .reset(reset), .in_a(a1), .in_b(b1), .in_c(c1),
`ifdef PIPE_ADDER_SUB_EN
    .in_sub(sub1),
`endif
    .in_valid(v1), .in_ready(rdy1), .out_s(s1), .out_c(co1),
    .out_valid(ov1), .out_ready(ordy1));

  int passed = 0;
  int total = 0;
  int fails = 0;
  int n_out = 0;
  logic [8:0] q[$];
  logic stalled = 1'b0;
  logic [9:0] held = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result modulo 2^9
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic sub);
    int unsigned r;
    if (sub) r = int'(a) + (255 - int'(b)) + 1;
    else     r = int'(a) + int'(b) + int'(c);
    return 9'(r % 512);
  endfunction

  // One clock of the 4-stage instance: sample handshakes before the edge,
  // score the output, record the accepted operand set.
  task automatic tick4(output logic acc);
    logic ti, to;
    logic [8:0] e;
    #1;
    ti = v4 && rdy4 && !reset;
    to = ov4 && ordy4 && !reset;
    check("in_ready_rule", 64'(rdy4), 64'(ordy4 || !ov4));
    if (stalled && !reset) check("stall_hold", 64'({ov4, co4, s4}), 64'(held));
    if (to) begin
      check("out_expected", 64'(q.size() > 0), 64'(1));
      if (q.size() > 0) begin
        e = q.pop_front();
        check("out_data", 64'({co4, s4}), 64'(e));
        n_out++;
      end
    end
    stalled = ov4 && !ordy4;
    held = {ov4, co4, s4};
    if (ti) q.push_back(model8(a4, b4, c4, sub4));
    @(posedge clk);
    if (reset) begin
      q.delete();
      stalled = 1'b0;
    end
    #1;
    acc = ti;
  endtask

  task automatic drain4();
    logic acc;
    v4 = 1'b0;
    ordy4 = 1'b1;
    for (int i = 0; i < 30 && (q.size() > 0 || ov4); i++) tick4(acc);
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
    logic acc;
    a4 = a; b4 = b; c4 = c; sub4 = sub; v4 = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick4(acc);
    check("send_accepted", 64'(acc), 64'(1));
    v4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [6:0] e1;
    int next;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ov4), 64'(0));
    check("rst_out_s", 64'(s4), 64'(0));
    check("rst_out_c", 64'(co4), 64'(0));
    check("rst_in_ready", 64'(rdy4), 64'(1));
    check("rst_out_valid_s2", 64'(ov2), 64'(0));
    check("rst_out_valid_s1", 64'(ov1), 64'(0));
    reset = 1'b0;

    // Latency on STAGES=2: FF + 00 + 1
    a2 = 8'hFF; b2 = 8'h00; c2 = 1'b1; v2 = 1'b1;
    #1;
    check("lat_ready", 64'(rdy2), 64'(1));
    @(posedge clk); #1;
    v2 = 1'b0;
    check("lat_not_yet", 64'(ov2), 64'(0));
    @(posedge clk); #1;
    check("lat_result", 64'({ov2, co2, s2}), 64'({1'b1, model8(8'hFF, 8'h00, 1'b1, 1'b0)}));
    @(posedge clk); #1;
    check("lat_one_shot", 64'(ov2), 64'(0));

    // Exhaustive on WIDTH=5, STAGES=1
    v1 = 1'b1; c1 = 1'b0;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        a1 = 5'(a); b1 = 5'(b);
        @(posedge clk); #1;
        e1 = {1'b1, 6'(a + b)};
        check("exhaustive", 64'({ov1, co1, s1}), 64'(e1));
      end
    end
    v1 = 1'b0;

    // Stream A=0..9, B=3 with out_ready low in cycles 3..6
    next = 0;
    n_out = 0;
    for (int i = 0; i < 40 && (next < 10 || q.size() > 0 || ov4); i++) begin
      ordy4 = !(i >= 3 && i <= 6);
      if (next < 10) begin
        v4 = 1'b1; a4 = 8'(next); b4 = 8'd3; c4 = 1'b0; sub4 = 1'b0;
      end else begin
        v4 = 1'b0;
      end
      #1;
      if (ov4 && !ordy4) check("stall_in_ready_low", 64'(rdy4), 64'(0));
      tick4(acc);
      if (acc) next++;
    end
    check("stream_sent", 64'(next), 64'(10));
    check("stream_received", 64'(n_out), 64'(10));
    drain4();

    // Wrap-around and carry corners
    send4(8'hFF, 8'h01, 1'b0, 1'b0);
    send4(8'hFF, 8'hFF, 1'b1, 1'b0);
    send4(8'h00, 8'h00, 1'b0, 1'b0);
    drain4();

`ifdef PIPE_ADDER_SUB_EN
    send4(8'd5, 8'd7, 1'b0, 1'b1);
    send4(8'd7, 8'd5, 1'b1, 1'b1);
    send4(8'd7, 8'd5, 1'b0, 1'b0);
    drain4();
`endif

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      v4 = ($urandom_range(0, 9) < 7);
      ordy4 = ($urandom_range(0, 9) < 7);
      a4 = 8'($urandom); b4 = 8'($urandom); c4 = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
      sub4 = 1'($urandom);
`endif
      tick4(acc);
    end
    drain4();
    sub4 = 1'b0;

    // Reset mid-flight discards three accepted sets
    ordy4 = 1'b1;
    send4(8'h11, 8'h22, 1'b0, 1'b0);
    send4(8'h33, 8'h44, 1'b1, 1'b0);
    send4(8'h55, 8'h66, 1'b0, 1'b0);
    n_out = 0;
    reset = 1'b1;
    v4 = 1'b1; a4 = 8'h77; b4 = 8'h01; c4 = 1'b0;
    tick4(acc);
    check("reset_cycle_not_accepted", 64'(acc), 64'(0));
    reset = 1'b0;
    v4 = 1'b0;
    check("post_reset_out_valid", 64'(ov4), 64'(0));
    check("post_reset_out_s", 64'(s4), 64'(0));
    check("post_reset_out_c", 64'(co4), 64'(0));
    check("post_reset_in_ready", 64'(rdy4), 64'(1));
    for (int i = 0; i < 10; i++) tick4(acc);
    check("post_reset_no_results", 64'(n_out), 64'(0));
    check("post_reset_idle", 64'(ov4), 64'(0));

    // Pipe still works after reset
    send4(8'h80, 8'h80, 1'b1, 1'b0);
    drain4();
    check("post_reset_result_count", 64'(n_out), 64'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
